alu32_pipe: RTL and testbench
=============================

# alu32_pipe

Registered, flow-controlled wrapper around the 32-bit integer ALU function set, used by the processor datapath and by block-level benches that push operand/op pairs and consume results. It accepts one request per cycle through a valid/ready handshake, executes through a two-stage pipeline, and returns result, overflow and zero with backpressure. It also keeps a sticky overflow flag and a completed-operation counter for status readback.

## Interface
- No parameters; datapath width is fixed at 32 bits.

- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  request present
- in_ready  output  1  request accepted this cycle when in_valid & in_ready
- A  input  32  operand A
- B  input  32  operand B
- ALUctl  input  4  operation select
- out_valid  output  1  response present
- out_ready  input  1  consumer takes response when out_valid & out_ready
- result  output  32  operation result
- overflow  output  1  signed overflow, ADD/SUB only
- zero  output  1  result == 0
- illegal  output  1  ALUctl was not a defined code
- clr_status  input  1  synchronous clear of ovf_sticky and op_count
- ovf_sticky  output  1  set when any delivered response had overflow=1
- op_count  output  16  count of delivered responses, wraps at 16'hFFFF->0

## Operation
- ALUctl codes: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR, 1101 NAND. Any other code: result 0, overflow 0, zero 1, illegal 1.
- ADD: A+B mod 2^32; overflow = (A[31]==B[31]) & (result[31]!=A[31]).
- SUB: A-B mod 2^32; overflow = (A[31]!=B[31]) & (result[31]!=A[31]).
- SLT: signed compare; result = {31'b0, diff[31] ^ sub_ovf} where diff = A-B; correct across overflow; overflow output 0.
- Logic ops and SLT: overflow 0.
- zero derived from the registered result, for every op.
- Stage 1 (S1): operand register A/B/ALUctl plus valid bit. Stage 2 (S2): computed result/flags register plus valid bit; S2 drives all out_* directly.
- S2 loads when S2 empty or out_ready; S1 advances into S2 under the same condition.
- in_ready = !S1.valid | !S2.valid | out_ready (combinational from out_ready; documented path).
- Delivery event = out_valid & out_ready: op_count increments; ovf_sticky |= overflow.
- clr_status same cycle as a delivery: clear wins, counter goes to 0, sticky to 0.
- Outputs held stable while out_valid & !out_ready; S1 holds its entry; in_ready low when both stages full.

## Timing
- Reset (async assert, sync-released use on next edge): S1/S2 valid 0, out_valid 0, result 0, overflow 0, zero 1, illegal 0, ovf_sticky 0, op_count 0; in_ready 1 during and after reset.
- Latency: request accepted at edge N -> out_valid at edge N+2 (visible after edge N+2) with out_ready held high.
- Throughput: one op/cycle with out_ready high; no bubbles.
- Stall: out_ready low with both stages full -> in_ready 0 next cycle; out_ready returning high restores in_ready combinationally that cycle; no data loss or duplication.
- Reset mid-operation: both in-flight entries discarded, no delivery counted.
- Order preserved; capacity exactly 2 entries.

## Test plan
- ADD sweep, out_ready=1: 4000_0000+4000_0000 -> 8000_0000 ovf1; C000_0000+C000_0000 -> 8000_0000 ovf0; 8000_0000+8000_0000 -> 0 ovf1 zero1; each out_valid exactly 2 cycles after accept.
- SUB/SLT: AAAA_AAAA-5555_5555 -> 5555_5555 ovf1; C000_0000-8000_0000 -> 4000_0000 ovf0; SLT AAAA_AAAA,1555_5555 -> 1; SLT 0,FFFF_FFFF -> 0; SLT FFFF_FFFF,0 -> 1.
- Logic: AND C000_0000,8000_0000 -> 8000_0000; NOR 0,4000_0000 -> BFFF_FFFF; NAND FFFF_FFFF,FFFF_FFFF -> 0 zero1; ALUctl 0011 -> result 0, illegal 1.
- Backpressure: stream 6 back-to-back ADDs, out_ready low 5 cycles mid-stream -> in_ready drops after 2 held entries, outputs stable, all 6 delivered in order, op_count 6.
- Status: deliver one overflowing ADD -> ovf_sticky 1; clr_status coincident with a delivery -> op_count 0, ovf_sticky 0 next cycle; 65536 deliveries from 0 -> op_count wraps to 0.
- Reset with 2 entries in flight -> out_valid 0, op_count 0, no response emitted after release; next request returns normally at latency 2.

Source files
------------

// File: rtl/alu32_pipe.sv
// Two-stage, valid/ready pipelined 32-bit ALU with sticky overflow and a delivered-op counter.
// Stage 1 holds the operands; stage 2 holds the computed result and drives the response directly.
module alu32_pipe (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [3:0]  ALUctl,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        overflow,
    output logic        zero,
    output logic        illegal,
    input  logic        clr_status,
    output logic        ovf_sticky,
    output logic [15:0] op_count
);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_NOR  = 4'b1100;
    localparam logic [3:0] OP_NAND = 4'b1101;

    logic        s1_valid_q, s1_valid_d;
    logic [31:0] s1_a_q, s1_a_d;
    logic [31:0] s1_b_q, s1_b_d;
    logic [3:0]  s1_ctl_q, s1_ctl_d;
    logic        s2_valid_q, s2_valid_d;
    logic [31:0] s2_result_q, s2_result_d;
    logic        s2_ovf_q, s2_ovf_d;
    logic        s2_illegal_q, s2_illegal_d;
    logic        ovf_sticky_q, ovf_sticky_d;
    logic [15:0] op_count_q, op_count_d;

    logic        accept;
    logic        advance;
    logic        deliver;

    logic [31:0] and_v;
    logic [31:0] or_v;
    logic [31:0] sum_v;
    logic [31:0] diff_v;
    logic        add_ovf;
    logic        sub_ovf;
    logic [31:0] alu_result;
    logic        alu_ovf;
    logic        alu_illegal;

    // Stage 2 frees up whenever it is empty or its entry is being consumed;
    // stage 1 moves forward under exactly the same condition.
    assign advance  = !s2_valid_q || out_ready;
    assign in_ready = !s1_valid_q || !s2_valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    assign deliver  = s2_valid_q && out_ready;

    genvar gi;
    generate
        for (gi = 0; gi < 32; gi++) begin : g_bitwise
            assign and_v[gi] = s1_a_q[gi] & s1_b_q[gi];
            assign or_v[gi]  = s1_a_q[gi] | s1_b_q[gi];
        end
    endgenerate

    assign sum_v   = s1_a_q + s1_b_q;
    assign diff_v  = s1_a_q - s1_b_q;
    assign add_ovf = (s1_a_q[31] == s1_b_q[31]) && (sum_v[31] != s1_a_q[31]);
    assign sub_ovf = (s1_a_q[31] != s1_b_q[31]) && (diff_v[31] != s1_a_q[31]);

    always_comb begin
        alu_result  = 32'd0;
        alu_ovf     = 1'b0;
        alu_illegal = 1'b0;
        unique case (s1_ctl_q)
            OP_AND:  alu_result = and_v;
            OP_OR:   alu_result = or_v;
            OP_ADD: begin
                alu_result = sum_v;
                alu_ovf    = add_ovf;
            end
            OP_SUB: begin
                alu_result = diff_v;
                alu_ovf    = sub_ovf;
            end
            // Sign of the true difference: flip the wrapped sign bit when the subtract overflowed.
            OP_SLT:  alu_result = {31'd0, diff_v[31] ^ sub_ovf};
            OP_NOR:  alu_result = ~or_v;
            OP_NAND: alu_result = ~and_v;
            default: alu_illegal = 1'b1;
        endcase
    end

    always_comb begin
        s1_valid_d   = s1_valid_q;
        s1_a_d       = s1_a_q;
        s1_b_d       = s1_b_q;
        s1_ctl_d     = s1_ctl_q;
        s2_valid_d   = s2_valid_q;
        s2_result_d  = s2_result_q;
        s2_ovf_d     = s2_ovf_q;
        s2_illegal_d = s2_illegal_q;

        if (advance) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_result_d  = alu_result;
                s2_ovf_d     = alu_ovf;
                s2_illegal_d = alu_illegal;
            end
            s1_valid_d = 1'b0;
        end

        if (accept) begin
            s1_valid_d = 1'b1;
            s1_a_d     = A;
            s1_b_d     = B;
            s1_ctl_d   = ALUctl;
        end
    end

    // A clear coincident with a delivery takes priority over the update.
    always_comb begin
        ovf_sticky_d = ovf_sticky_q;
        op_count_d   = op_count_q;
        if (clr_status) begin
            ovf_sticky_d = 1'b0;
            op_count_d   = 16'd0;
        end else if (deliver) begin
            ovf_sticky_d = ovf_sticky_q | s2_ovf_q;
            op_count_d   = op_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q   <= 1'b0;
            s1_a_q       <= 32'd0;
            s1_b_q       <= 32'd0;
            s1_ctl_q     <= 4'd0;
            s2_valid_q   <= 1'b0;
            s2_result_q  <= 32'd0;
            s2_ovf_q     <= 1'b0;
            s2_illegal_q <= 1'b0;
            ovf_sticky_q <= 1'b0;
            op_count_q   <= 16'd0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_a_q       <= s1_a_d;
            s1_b_q       <= s1_b_d;
            s1_ctl_q     <= s1_ctl_d;
            s2_valid_q   <= s2_valid_d;
            s2_result_q  <= s2_result_d;
            s2_ovf_q     <= s2_ovf_d;
            s2_illegal_q <= s2_illegal_d;
            ovf_sticky_q <= ovf_sticky_d;
            op_count_q   <= op_count_d;
        end
    end

    assign out_valid  = s2_valid_q;
    assign result     = s2_result_q;
    assign overflow   = s2_ovf_q;
    assign zero       = (s2_result_q == 32'd0);
    assign illegal    = s2_illegal_q;
    assign ovf_sticky = ovf_sticky_q;
    assign op_count   = op_count_q;

endmodule

// File: tb/tb_alu32_pipe.sv
// Directed bench for alu32_pipe: operations, latency, backpressure, status counters, reset.
`timescale 1ns/1ps
module tb_alu32_pipe;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] A;
    logic [31:0] B;
    logic [3:0]  ALUctl;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        overflow;
    logic        zero;
    logic        illegal;
    logic        clr_status;
    logic        ovf_sticky;
    logic [15:0] op_count;

    int n_checks;
    int n_fail;

    alu32_pipe dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .A          (A),
        .B          (B),
        .ALUctl     (ALUctl),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .overflow   (overflow),
        .zero       (zero),
        .illegal    (illegal),
        .clr_status (clr_status),
        .ovf_sticky (ovf_sticky),
        .op_count   (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Presents one request with out_ready high, returns the response and the number of
    // edges from presentation until out_valid was seen; then lets the delivery happen.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [3:0] ctl,
                          output logic [31:0] res, output logic ovf, output logic zr,
                          output logic ill, output int lat);
        in_valid  = 1'b1;
        A         = a;
        B         = b;
        ALUctl    = ctl;
        out_ready = 1'b1;
        lat = 0;
        do begin
            @(posedge clk); #1;
            in_valid = 1'b0;
            lat++;
        end while (!out_valid && lat < 8);
        res = result;
        ovf = overflow;
        zr  = zero;
        ill = illegal;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        n_checks++;
        if ({out_valid, result, overflow, zero, illegal, ovf_sticky, op_count, in_ready}
            !== {1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_state: ov=%b res=%h ovf=%b z=%b ill=%b st=%b cnt=%0d rdy=%b, want 0 0 0 1 0 0 0 1",
                     out_valid, result, overflow, zero, illegal, ovf_sticky, op_count, in_ready);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL post_reset: out_valid=%b in_ready=%b, want 0 1", out_valid, in_ready);
        end
        $display("test_reset done");
    endtask

    task automatic test_add();
        logic [31:0] ta [3] = '{32'h4000_0000, 32'hC000_0000, 32'h8000_0000};
        logic [31:0] er [3] = '{32'h8000_0000, 32'h8000_0000, 32'h0000_0000};
        logic        eo [3] = '{1'b1, 1'b0, 1'b1};
        logic        ez [3] = '{1'b0, 1'b0, 1'b1};
        logic [31:0] res;
        logic        ovf, zr, ill;
        int          lat;
        for (int i = 0; i < 3; i++) begin
            run_op(ta[i], ta[i], 4'b0010, res, ovf, zr, ill, lat);
            $display("ADD %h+%h -> %h ovf=%b zero=%b lat=%0d", ta[i], ta[i], res, ovf, zr, lat);
            n_checks++;
            if ({res, ovf, zr, ill} !== {er[i], eo[i], ez[i], 1'b0}) begin
                n_fail++;
                $display("FAIL add_%0d: got %h/%b/%b/%b want %h/%b/%b/0", i, res, ovf, zr, ill, er[i], eo[i], ez[i]);
            end
            n_checks++;
            if (lat !== 2) begin
                n_fail++;
                $display("FAIL add_latency_%0d: got %0d want 2", i, lat);
            end
        end
    endtask

    task automatic test_sub_slt();
        logic [31:0] ta [5] = '{32'hAAAA_AAAA, 32'hC000_0000, 32'hAAAA_AAAA, 32'h0000_0000, 32'hFFFF_FFFF};
        logic [31:0] tb [5] = '{32'h5555_5555, 32'h8000_0000, 32'h1555_5555, 32'hFFFF_FFFF, 32'h0000_0000};
        logic [3:0]  tc [5] = '{4'b0110, 4'b0110, 4'b0111, 4'b0111, 4'b0111};
        logic [31:0] er [5] = '{32'h5555_5555, 32'h4000_0000, 32'd1, 32'd0, 32'd1};
        logic        eo [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        logic [31:0] res;
        logic        ovf, zr, ill;
        int          lat;
        for (int i = 0; i < 5; i++) begin
            run_op(ta[i], tb[i], tc[i], res, ovf, zr, ill, lat);
            $display("SUB/SLT ctl=%b %h,%h -> %h ovf=%b zero=%b", tc[i], ta[i], tb[i], res, ovf, zr);
            n_checks++;
            if ({res, ovf, zr, ill} !== {er[i], eo[i], (er[i] == 32'd0), 1'b0}) begin
                n_fail++;
                $display("FAIL subslt_%0d: got %h/%b/%b/%b want %h/%b/%b/0", i, res, ovf, zr, ill,
                         er[i], eo[i], (er[i] == 32'd0));
            end
        end
    endtask

    task automatic test_logic();
        logic [31:0] ta [5] = '{32'hC000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 32'h1234_0000, 32'hFFFF_FFFF};
        logic [31:0] tb [5] = '{32'h8000_0000, 32'h4000_0000, 32'hFFFF_FFFF, 32'h0000_5678, 32'hFFFF_FFFF};
        logic [3:0]  tc [5] = '{4'b0000, 4'b1100, 4'b1101, 4'b0001, 4'b0011};
        logic [31:0] er [5] = '{32'h8000_0000, 32'hBFFF_FFFF, 32'd0, 32'h1234_5678, 32'd0};
        logic        ei [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic [31:0] res;
        logic        ovf, zr, ill;
        int          lat;
        for (int i = 0; i < 5; i++) begin
            run_op(ta[i], tb[i], tc[i], res, ovf, zr, ill, lat);
            $display("LOGIC ctl=%b %h,%h -> %h zero=%b illegal=%b", tc[i], ta[i], tb[i], res, zr, ill);
            n_checks++;
            if ({res, ovf, zr, ill} !== {er[i], 1'b0, (er[i] == 32'd0), ei[i]}) begin
                n_fail++;
                $display("FAIL logic_%0d: got %h/%b/%b/%b want %h/0/%b/%b", i, res, ovf, zr, ill,
                         er[i], (er[i] == 32'd0), ei[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_q[$];
        logic [31:0] prev_res;
        logic        prev_stall;
        logic        acc, dlv;
        int          sent, delivered, stall_low;
        clr_status = 1'b1;
        @(posedge clk); #1;
        clr_status = 1'b0;
        sent = 0; delivered = 0; stall_low = 0;
        prev_stall = 1'b0; prev_res = 32'd0;
        for (int c = 0; c < 40 && delivered < 6; c++) begin
            out_ready = !(c >= 2 && c < 7);
            in_valid  = (sent < 6);
            A         = 32'h100 * (sent + 1);
            B         = 32'd7;
            ALUctl    = 4'b0010;
            #1;
            if (c >= 2 && c < 7) begin
                n_checks++;
                if (in_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL stall_in_ready c=%0d: got %b want 0", c, in_ready);
                end
            end
            if (c == 7) begin
                n_checks++;
                if (in_ready !== 1'b1) begin
                    n_fail++;
                    $display("FAIL resume_in_ready: got %b want 1", in_ready);
                end
            end
            if (prev_stall) begin
                n_checks++;
                if (out_valid !== 1'b1 || result !== prev_res) begin
                    n_fail++;
                    $display("FAIL stall_hold c=%0d: got %b/%h want 1/%h", c, out_valid, result, prev_res);
                end
            end
            acc = in_valid && in_ready;
            dlv = out_valid && out_ready;
            if (acc) exp_q.push_back(32'h100 * (sent + 1) + 32'd7);
            if (dlv) begin
                $display("B2B deliver #%0d result=%h", delivered, result);
                n_checks++;
                if (exp_q.size() == 0 || result !== exp_q[0]) begin
                    n_fail++;
                    $display("FAIL b2b_order_%0d: got %h want %h", delivered, result,
                             (exp_q.size() == 0) ? 32'hX : exp_q[0]);
                end
                if (exp_q.size() != 0) void'(exp_q.pop_front());
            end
            prev_stall = out_valid && !out_ready;
            prev_res   = result;
            if (!out_ready && out_valid) stall_low++;
            @(posedge clk); #1;
            if (acc) sent++;
            if (dlv) delivered++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        n_checks++;
        if (delivered !== 6 || op_count !== 16'd6) begin
            n_fail++;
            $display("FAIL b2b_total: delivered=%0d op_count=%0d want 6 6", delivered, op_count);
        end
        $display("test_back_to_back done, stalled cycles=%0d", stall_low);
    endtask

    task automatic test_status();
        logic [31:0] res;
        logic        ovf, zr, ill;
        int          lat;
        clr_status = 1'b1;
        @(posedge clk); #1;
        clr_status = 1'b0;
        run_op(32'h7FFF_FFFF, 32'd1, 4'b0010, res, ovf, zr, ill, lat);
        $display("STATUS after ovf add: sticky=%b count=%0d", ovf_sticky, op_count);
        n_checks++;
        if (ovf_sticky !== 1'b1 || op_count !== 16'd1) begin
            n_fail++;
            $display("FAIL sticky_set: sticky=%b count=%0d want 1 1", ovf_sticky, op_count);
        end
        in_valid  = 1'b1;
        A         = 32'h4000_0000;
        B         = 32'h4000_0000;
        ALUctl    = 4'b0010;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        clr_status = 1'b1;
        n_checks++;
        if (out_valid !== 1'b1 || overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL clr_setup: out_valid=%b overflow=%b want 1 1", out_valid, overflow);
        end
        @(posedge clk); #1;
        clr_status = 1'b0;
        $display("STATUS after coincident clear: sticky=%b count=%0d", ovf_sticky, op_count);
        n_checks++;
        if (ovf_sticky !== 1'b0 || op_count !== 16'd0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL clr_wins: sticky=%b count=%0d out_valid=%b want 0 0 0", ovf_sticky, op_count, out_valid);
        end
    endtask

    task automatic test_wrap();
        logic acc, dlv;
        int   sent, delivered, cyc;
        sent = 0; delivered = 0; cyc = 0;
        in_valid  = 1'b1;
        A         = 32'd1;
        B         = 32'd1;
        ALUctl    = 4'b0010;
        out_ready = 1'b1;
        while (delivered < 65536 && cyc < 70000) begin
            #1;
            acc = in_valid && in_ready;
            dlv = out_valid && out_ready;
            @(posedge clk); #1;
            if (acc) sent++;
            if (dlv) delivered++;
            in_valid = (sent < 65536);
            cyc++;
            if (dlv && delivered == 65535) begin
                n_checks++;
                if (op_count !== 16'hFFFF) begin
                    n_fail++;
                    $display("FAIL wrap_ffff: got %h want ffff", op_count);
                end
            end
        end
        in_valid = 1'b0;
        $display("WRAP delivered=%0d cycles=%0d op_count=%0d", delivered, cyc, op_count);
        n_checks++;
        if (delivered !== 65536 || op_count !== 16'd0) begin
            n_fail++;
            $display("FAIL wrap_zero: delivered=%0d op_count=%0d want 65536 0", delivered, op_count);
        end
    endtask

    task automatic test_reset_midflight();
        logic [31:0] res;
        logic        ovf, zr, ill;
        int          lat, seen;
        run_op(32'd3, 32'd4, 4'b0010, res, ovf, zr, ill, lat);
        in_valid  = 1'b1;
        A         = 32'd10;
        B         = 32'd20;
        ALUctl    = 4'b0010;
        out_ready = 1'b0;
        @(posedge clk); #1;
        A = 32'd30;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0 || op_count !== 16'd1) begin
            n_fail++;
            $display("FAIL midflight_setup: out_valid=%b in_ready=%b count=%0d want 1 0 1",
                     out_valid, in_ready, op_count);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || op_count !== 16'd0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL midflight_reset: out_valid=%b count=%0d in_ready=%b want 0 0 1",
                     out_valid, op_count, in_ready);
        end
        @(posedge clk); #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        n_checks++;
        if (seen !== 0 || op_count !== 16'd0) begin
            n_fail++;
            $display("FAIL midflight_drain: responses=%0d count=%0d want 0 0", seen, op_count);
        end
        run_op(32'h0000_0010, 32'h0000_0020, 4'b0010, res, ovf, zr, ill, lat);
        $display("POST-RESET op -> %h lat=%0d", res, lat);
        n_checks++;
        if (res !== 32'h30 || lat !== 2 || op_count !== 16'd1) begin
            n_fail++;
            $display("FAIL post_reset_op: res=%h lat=%0d count=%0d want 30 2 1", res, lat, op_count);
        end
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        A          = 32'd0;
        B          = 32'd0;
        ALUctl     = 4'd0;
        out_ready  = 1'b1;
        clr_status = 1'b0;
        test_reset();
        test_add();
        test_sub_slt();
        test_logic();
        test_back_to_back();
        test_status();
        test_wrap();
        test_reset_midflight();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
